// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift operation encodings and an elaboration-time log2 helper.
package alu_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_e;

    // Ceiling log2, used to size shift-amount fields and the number of log stages.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_2.sv
// Single-bit two-input multiplexer cell.
module mux_2 (
    input  logic a_i,
    input  logic b_i,
    input  logic sel_i,
    output logic y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/shift_stage.sv
// One combinational log stage of the barrel shifter: optionally shifts right by DIST.
// Vacated MSBs take either the wrapped-around LSBs (rotate) or the fill bit.
module shift_stage #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             sel_i,
    input  logic             rot_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] shifted;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        if (b + DIST < WIDTH) begin : g_inner
            assign shifted[b] = data_i[b + DIST];
        end else begin : g_edge
            assign shifted[b] = rot_i ? data_i[b + DIST - WIDTH] : fill_i;
        end

        mux_2 u_mux (
            .a_i   (data_i[b]),
            .b_i   (shifted[b]),
            .sel_i (sel_i),
            .y_o   (data_o[b])
        );
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake and a pass-through tag.
// All modes run through a right-shifting datapath; SLL bit-reverses the operand on entry and
// the result before it is captured in the final slot, so outputs come straight from registers.
module shift_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [clog2(WIDTH)-1:0]   in_shamt,
    input  logic [1:0]                in_op,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [TAG_W-1:0]          out_tag
);

    localparam int S = clog2(WIDTH);
    localparam int L = (S + REG_EVERY - 1) / REG_EVERY;

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int b = 0; b < WIDTH; b++) r[b] = v[WIDTH-1-b];
        return r;
    endfunction

    // Slot registers: one per pipeline register position, the last one drives the outputs.
    logic [L-1:0]       vld_q;
    logic [WIDTH-1:0]   data_q  [L];
    logic [1:0]         op_q    [L];
    logic [S-1:0]       shamt_q [L];
    logic [L-1:0]       sign_q;
    logic [TAG_W-1:0]   tag_q   [L];

    // Values feeding each slot's log stages (inputs for slot 0, previous slot otherwise).
    logic [L-1:0]       src_vld;
    logic [WIDTH-1:0]   src_data  [L];
    logic [1:0]         src_op    [L];
    logic [S-1:0]       src_shamt [L];
    logic [L-1:0]       src_sign;
    logic [TAG_W-1:0]   src_tag   [L];

    logic [WIDTH-1:0]   data_d [L];
    logic [WIDTH-1:0]   st_in  [S];
    logic [WIDTH-1:0]   st_out [S];
    logic [L-1:0]       load;

    // Select the source of every slot: entry operands for slot 0, upstream registers after.
    always_comb begin
        src_vld[0]   = in_valid;
        src_data[0]  = (in_op == SHIFT_SLL) ? rev(in_data) : in_data;
        src_op[0]    = in_op;
        src_shamt[0] = in_shamt;
        src_sign[0]  = in_data[WIDTH-1];
        src_tag[0]   = in_tag;
        for (int j = 1; j < L; j++) begin
            src_vld[j]   = vld_q[j-1];
            src_data[j]  = data_q[j-1];
            src_op[j]    = op_q[j-1];
            src_shamt[j] = shamt_q[j-1];
            src_sign[j]  = sign_q[j-1];
            src_tag[j]   = tag_q[j-1];
        end
    end

    // Log stage k shifts by 2^k and belongs to slot k / REG_EVERY.
    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int J = k / REG_EVERY;

        if (k % REG_EVERY == 0) begin : g_first
            assign st_in[k] = src_data[J];
        end else begin : g_chain
            assign st_in[k] = st_out[k-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data_i (st_in[k]),
            .sel_i  (src_shamt[J][k]),
            .rot_i  (src_op[J] == SHIFT_ROR),
            .fill_i (src_sign[J] && (src_op[J] == SHIFT_SRA)),
            .data_o (st_out[k])
        );
    end

    // Each slot captures the output of its last log stage; the final slot undoes the SLL reversal.
    for (genvar j = 0; j < L; j++) begin : g_slot
        localparam int LAST = ((j + 1) * REG_EVERY > S) ? S - 1 : (j + 1) * REG_EVERY - 1;

        if (j == L - 1) begin : g_exit
            assign data_d[j] = (src_op[j] == SHIFT_SLL) ? rev(st_out[LAST]) : st_out[LAST];
        end else begin : g_mid
            assign data_d[j] = st_out[LAST];
        end
    end

    // Ready ripples back from the consumer: a slot loads when empty or when its successor loads.
    always_comb begin
        logic rdy;
        rdy  = out_ready;
        load = '0;
        for (int j = L - 1; j >= 0; j--) begin
            load[j] = reset || !vld_q[j] || rdy;
            rdy     = load[j];
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld_q[L-1];
    assign out_data  = data_q[L-1];
    assign out_tag   = tag_q[L-1];

    // Valid flags: cleared by reset, otherwise follow the upstream slot whenever the slot loads.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            for (int j = 0; j < L; j++) begin
                if (load[j]) vld_q[j] <= src_vld[j];
            end
        end
    end

    // Payload registers: only the output slot is cleared so out_data/out_tag come up as zero.
    always_ff @(posedge clock) begin
        for (int j = 0; j < L; j++) begin
            if (reset && (j == L - 1)) begin
                data_q[j] <= '0;
                tag_q[j]  <= '0;
            end else if (load[j]) begin
                data_q[j]  <= data_d[j];
                op_q[j]    <= src_op[j];
                shamt_q[j] <= src_shamt[j];
                sign_q[j]  <= src_sign[j];
                tag_q[j]   <= src_tag[j];
            end
        end
    end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: a 32-bit/REG_EVERY=2 instance driven with directed and
// random traffic, and an 8-bit/REG_EVERY=1 instance driven exhaustively, both scored against
// an arithmetic reference model and an in-order expectation queue.
module tb_shift_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        a_iv, a_ir, a_ov, a_or;
    logic [31:0] a_d, a_od;
    logic [4:0]  a_sh, a_tag, a_ot;
    logic [1:0]  a_op;

    // 8-bit instance
    logic        b_iv, b_ir, b_ov, b_or;
    logic [7:0]  b_d, b_od;
    logic [2:0]  b_sh;
    logic [4:0]  b_tag, b_ot;
    logic [1:0]  b_op;

    shift_pipe #(.WIDTH(32), .REG_EVERY(2), .TAG_W(5)) dut (
        .clock(clk), .reset(rst),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d), .in_shamt(a_sh), .in_op(a_op), .in_tag(a_tag),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_tag(a_ot)
    );

    shift_pipe #(.WIDTH(8), .REG_EVERY(1), .TAG_W(5)) dut8 (
        .clock(clk), .reset(rst),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d), .in_shamt(b_sh), .in_op(b_op), .in_tag(b_tag),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_tag(b_ot)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int b_acc  = 0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: shifts expressed directly on integers of width w.
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int s, input logic [1:0] op, input int w);
        logic [63:0] mask, x, r;
        mask = (64'd1 << w) - 64'd1;
        x    = d & mask;
        case (op)
            2'b00:   r = (x << s) & mask;
            2'b01:   r = x >> s;
            2'b10: begin
                r = x >> s;
                if (x[w-1]) r = r | (mask & ~(mask >> s));
            end
            default: r = (s == 0) ? x : (((x >> s) | (x << (w - s))) & mask);
        endcase
        return r;
    endfunction

    // Scoreboard: every output cycle is compared with the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_ov === 1'b1) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_out", 64'(a_ov), 64'd0);
                end else begin
                    chk("a_data", 64'(a_od), 64'(qa[0].d));
                    chk("a_tag", 64'(a_ot), 64'(qa[0].t));
                    if (a_or) void'(qa.pop_front());
                end
            end
            if (a_iv && a_ir) begin
                e = ref_shift(64'(a_d), int'(a_sh), a_op, 32);
                qa.push_back('{d: e[31:0], t: a_tag});
            end
            if (b_ov === 1'b1) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_out", 64'(b_ov), 64'd0);
                end else begin
                    chk("b_data", 64'(b_od), 64'(qb[0].d));
                    chk("b_tag", 64'(b_ot), 64'(qb[0].t));
                    if (b_or) void'(qb.pop_front());
                end
            end
            if (b_iv && b_ir) begin
                b_acc++;
                e = ref_shift(64'(b_d), int'(b_sh), b_op, 8);
                qb.push_back('{d: e[31:0], t: b_tag});
            end
        end
    end

    // Present one op to the 32-bit instance and hold it until accepted (call just after a posedge).
    task automatic send_a(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op, input logic [4:0] tag);
        int n;
        a_d = d; a_sh = sh; a_op = op; a_tag = tag; a_iv = 1'b1;
        n = 0;
        @(negedge clk);
        while (a_ir !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (a_ir !== 1'b1) chk("send_timeout", 64'(a_ir), 64'd1);
        @(posedge clk); #1;
        a_iv = 1'b0;
    endtask

    // Single op through an idle pipe: check latency and a literal result.
    task automatic run_one(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                           input logic [31:0] exp, input string name);
        int lat;
        send_a(d, sh, op, 5'd9);
        lat = 1;
        @(negedge clk);
        while (a_ov !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'd3);
        chk(name, 64'(a_od), 64'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int lat;
        rst = 1'b1;
        a_iv = 1'b0; a_or = 1'b1; a_d = '0; a_sh = '0; a_op = '0; a_tag = '0;
        b_iv = 1'b0; b_or = 1'b1; b_d = '0; b_sh = '0; b_op = '0; b_tag = '0;

        // Pin the reference model with hand-computed values.
        chk("model_sra", ref_shift(64'h8000_0000, 31, 2'b10, 32), 64'hFFFF_FFFF);
        chk("model_srl", ref_shift(64'h8000_0000, 31, 2'b01, 32), 64'h1);
        chk("model_sll", ref_shift(64'h1, 31, 2'b00, 32), 64'h8000_0000);
        chk("model_ror", ref_shift(64'h1, 1, 2'b11, 32), 64'h8000_0000);
        chk("model_sra8", ref_shift(64'h81, 1, 2'b10, 8), 64'hC0);
        chk("model_ror8", ref_shift(64'h01, 3, 2'b11, 8), 64'h20);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", 64'(a_ov), 64'd0);
        chk("rst_in_ready", 64'(a_ir), 64'd1);
        chk("rst_out_data", 64'(a_od), 64'd0);
        chk("rst_out_tag", 64'(a_ot), 64'd0);
        chk("rst_b_out_valid", 64'(b_ov), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(a_ir), 64'd1);
        @(posedge clk); #1;

        // Directed single operations.
        run_one(32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, "sra31");
        run_one(32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, "srl31");
        run_one(32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, "sll31");
        run_one(32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000, "ror1");
        run_one(32'h0000_00F0, 5'd4,  2'b11, 32'h0000_000F, "ror4");
        for (int op = 0; op < 4; op++) run_one(32'hDEAD_BEEF, 5'd0, 2'(op), 32'hDEAD_BEEF, "shamt0");

        // Back-to-back: 8 results on consecutive cycles with tags 1..8.
        fork
            begin
                for (int i = 1; i <= 8; i++) send_a($urandom, 5'($urandom), 2'($urandom), 5'(i));
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (a_ov !== 1'b1 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 1; i <= 8; i++) begin
                    chk("b2b_valid_tag", 64'({a_ov, a_ot}), 64'({1'b1, 5'(i)}));
                    @(negedge clk);
                end
            end
        join
        @(posedge clk); #1;

        // Backpressure: the pipe takes exactly L ops, then stalls; release passes through.
        a_or = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            a_d = $urandom; a_sh = 5'($urandom); a_op = 2'($urandom); a_tag = 5'(c + 16); a_iv = 1'b1;
            @(negedge clk);
            if (a_ir !== 1'b1) break;
            acc++;
            @(posedge clk); #1;
        end
        chk("accepts_until_full", 64'(acc), 64'd3);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_in_ready", 64'(a_ir), 64'd0);
        @(posedge clk); #1;
        a_or = 1'b1;
        @(negedge clk);
        chk("full_pass_ready", 64'(a_ir), 64'd1);
        @(posedge clk); #1;
        a_iv = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("bp_drained", 64'(qa.size()), 64'd0);

        // Reset with two ops in flight: nothing may emerge afterwards.
        send_a(32'h1234_5678, 5'd3, 2'b01, 5'd21);
        send_a(32'h8765_4321, 5'd7, 2'b10, 5'd22);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(a_ov), 64'd0);
        chk("midrst_in_ready", 64'(a_ir), 64'd1);
        repeat (6) @(posedge clk);
        #1;

        // 8-bit instance: latency and a literal result.
        b_d = 8'h81; b_sh = 3'd1; b_op = 2'b10; b_tag = 5'd3; b_iv = 1'b1;
        @(negedge clk);
        chk("b_in_ready", 64'(b_ir), 64'd1);
        @(posedge clk); #1;
        b_iv = 1'b0;
        lat = 1;
        @(negedge clk);
        while (b_ov !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b_latency", 64'(lat), 64'd3);
        chk("b_sra_lit", 64'(b_od), 64'hC0);
        @(posedge clk); #1;

        // Random traffic on the 32-bit instance alongside the exhaustive 8-bit sweep.
        fork
            begin
                for (int c = 0; c < 3000; c++) begin
                    a_iv  = ($urandom_range(3) != 0);
                    a_or  = ($urandom_range(3) != 0);
                    a_d   = $urandom;
                    if ($urandom_range(3) == 0) a_d[31] = 1'b1;
                    a_sh  = 5'($urandom);
                    a_op  = 2'($urandom);
                    a_tag = 5'($urandom);
                    @(posedge clk); #1;
                end
                a_iv = 1'b0;
                a_or = 1'b1;
            end
            begin
                for (int op = 0; op < 4; op++) begin
                    for (int sh = 0; sh < 8; sh++) begin
                        for (int d = 0; d < 256; d++) begin
                            b_iv = 1'b1; b_d = 8'(d); b_sh = 3'(sh); b_op = 2'(op); b_tag = 5'(d);
                            @(posedge clk); #1;
                        end
                    end
                end
                b_iv = 1'b0;
            end
        join
        repeat (20) @(posedge clk);
        #1;
        chk("a_final_drained", 64'(qa.size()), 64'd0);
        chk("b_final_drained", 64'(qb.size()), 64'd0);
        // One latency probe plus the 4*8*256 sweep.
        chk("b_accept_count", 64'(b_acc), 64'd8193);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter; successor to the ALU's fixed 32-bit single-cycle arithmetic right shifter. Supports four shift modes (logical left, logical right, arithmetic right, rotate right) at any power-of-two width. Pipeline registers can be placed between log stages to close timing at FPGA clock rates. A valid/ready handshake with full backpressure lets it sit as a multi-cycle execution unit beside the ALU, and a sideband tag travels with each operation for writeback routing.

## Interface
- WIDTH, 32, data width; power of two, 4..64
- REG_EVERY, 2, pipeline register inserted after every REG_EVERY log stages; final stage always registered
- TAG_W, 5, sideband tag width (destination register index)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all valid flags
- in_valid  in  1  operation presented
- in_ready  out  1  unit accepts operation this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  log2(WIDTH)  shift amount, unsigned
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- in_tag  in  TAG_W  passed through unchanged
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  shifted result
- out_tag  out  TAG_W  tag of the operation producing out_data

## Operation
- S = log2(WIDTH) log stages; stage k (k = 0..S-1) shifts by 2^k when shamt[k] = 1, otherwise passes through.
- SLL: vacated LSBs are 0. SRL: vacated MSBs are 0. SRA: vacated MSBs equal operand bit WIDTH-1, captured at input and carried with the operation. ROR: bits leaving the LSB re-enter at the MSB.
- Left shift is implemented as bit-reverse, right shift, bit-reverse. Rotate uses the right path with wrap-around fill. The bit-reverse is applied at entry and undone at exit; it is not a separate datapath.
- shamt = 0 in any mode returns the operand unchanged. shamt is inherently modulo WIDTH; no out-of-range case exists.
- op, shamt bits for later stages, sign bit and tag are registered alongside data in every pipeline register.
- Pipeline slot j holds a valid bit. Slot j loads when !valid_j || ready_{j+1}. ready of the last slot = out_ready. in_ready = load enable of slot 0 (combinational from downstream).
- When slot j loads and its upstream slot has no valid operation, valid_j is cleared (bubble).
- Reset: every valid bit is cleared. out_valid = 0. out_data and out_tag are don't-care while out_valid = 0 but reset to 0. in_ready = 1 during and after the reset cycle.
- Reset mid-operation: in-flight operations are discarded silently.

## Timing
- Latency L = ceil(S / REG_EVERY) cycles from accepted input to out_valid. WIDTH=32, REG_EVERY=2: L = 3. REG_EVERY >= S: L = 1.
- Throughput 1 op/cycle while out_ready = 1.
- out_ready = 0 with a full pipe: in_ready = 0 in the same cycle. out_data/out_tag are held stable while out_valid && !out_ready.
- A bubble is filled: with out_ready = 0, in_ready stays 1 until every slot is valid.
- Simultaneous out accept and in accept on a full pipe: both complete; occupancy is unchanged.
- No combinational path from in_* to out_*. The only combinational path is out_ready -> in_ready.

## Structure
- Shared package alu_pkg: op encodings SHIFT_SLL/SRL/SRA/ROR; the clog2 helper.
- Sub-module shift_stage (parameters WIDTH, DIST): one combinational log stage with select, mode and fill inputs, built from the existing mux_2 cells.
- Top level: generates S shift_stage instances and conditional pipeline registers from REG_EVERY, plus the entry/exit bit-reversal.

## Test plan
- WIDTH=32, SRA 0x80000000 shamt 31 -> 0xFFFFFFFF; SRL same -> 0x00000001; out_valid exactly 3 cycles after accept.
- SLL 0x00000001 shamt 31 -> 0x80000000; ROR 0x00000001 shamt 1 -> 0x80000000; any op with shamt 0 on 0xDEADBEEF -> 0xDEADBEEF.
- Back-to-back 8 ops with tags 1..8 and out_ready=1 -> 8 results on consecutive cycles, tags in order 1..8.
- Hold out_ready=0, stream inputs -> in_ready drops after exactly L accepts; outputs stable; release -> no loss or duplication.
- Assert reset with 2 ops in flight -> out_valid=0 next cycle, in_ready=1, no stale result emerges afterwards.
- WIDTH=8, REG_EVERY=1: L=3. Exhaustive 256 operands × 8 shamts × 4 ops matches the reference model.
